// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter.
// Mode encodings and the one-shot FSM state.
package prog_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/prog_counter_if.sv
// Control and status bundle of the programmable counter.
// master drives controls, slave (the counter) drives status.
interface prog_counter_if #(
    parameter int WIDTH = 32
);
    logic             clear;
    logic             en;
    logic             up;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_max;
    logic             start;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
    logic             busy;

    modport master (
        output clear, en, up, mode, load, load_val,
        output cfg_we, cfg_max, start,
        input  count, tc, done, busy
    );

    modport slave (
        input  clear, en, up, mode, load, load_val,
        input  cfg_we, cfg_max, start,
        output count, tc, done, busy
    );
endinterface

// File: rtl/prog_counter_step.sv
// Combinational step: next count, terminal test and
// whether the step lands exactly on the bound.
module prog_counter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] lim_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             at_term_o,
    output logic             reach_bound_o
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Up: bound is lim, and anything above it (after a load)
    // counts as terminal. Down: bound is zero.
    always_comb begin
        nxt_o         = up_i ? count_i + ONE : count_i - ONE;
        at_term_o     = up_i ? (count_i >= lim_i) : (count_i == '0);
        reach_bound_o = up_i ? (nxt_o == lim_i) : (nxt_o == '0);
    end
endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap, saturate and
// one-shot modes, runtime limit and parallel load.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MAX_DEFAULT = 9
) (
    input  logic           clk,
    input  logic           reset,
    prog_counter_if.slave  bus
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] lim_q;
    logic             tc_q;
    logic             done_q;
    logic             busy_q;
    state_e           state_q;

    logic [WIDTH-1:0] nxt;
    logic             at_term;
    logic             reach_bound;
    logic             oneshot;

    prog_counter_step #(.WIDTH(WIDTH)) u_step (
        .count_i       (count_q),
        .lim_i         (lim_q),
        .up_i          (bus.up),
        .nxt_o         (nxt),
        .at_term_o     (at_term),
        .reach_bound_o (reach_bound)
    );

    assign oneshot = (bus.mode == MODE_ONESHOT);

    // Registers, priority clear > load > start > step, and FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            lim_q   <= WIDTH'(MAX_DEFAULT);
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            tc_q <= 1'b0;
            if (bus.cfg_we) lim_q <= bus.cfg_max;
            if (!oneshot) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
            if (bus.clear) begin
                count_q <= '0;
                done_q  <= 1'b0;
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (bus.load) begin
                count_q <= bus.load_val;
            end else if (bus.start && oneshot) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                count_q <= bus.up ? '0 : lim_q;
            end else if (bus.en) begin
                case (bus.mode)
                    MODE_SAT: begin
                        if (!at_term) begin
                            count_q <= nxt;
                            tc_q    <= reach_bound;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (state_q == RUN) begin
                            if (at_term || reach_bound) begin
                                tc_q    <= 1'b1;
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                            if (!at_term) count_q <= nxt;
                        end
                    end
                    default: begin
                        if (at_term) begin
                            count_q <= bus.up ? '0 : lim_q;
                            tc_q    <= 1'b1;
                        end else begin
                            count_q <= nxt;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter (WIDTH=8, MAX_DEFAULT=9).
// Table of per-cycle vectors plus hand-written sequences.
module tb_prog_counter;
    localparam int W = 8;

    typedef struct {
        logic       clr;
        logic       en;
        logic       up;
        logic [1:0] mode;
        logic       ld;
        logic [7:0] ldv;
        logic       we;
        logic [7:0] cmax;
        logic       st;
        logic [7:0] ec;
        logic       etc;
        logic       ed;
        logic       eb;
    } vec_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    vec_t tbl[$];

    prog_counter_if #(.WIDTH(W)) bus ();

    prog_counter #(.WIDTH(W), .MAX_DEFAULT(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int c, input int t,
                           input int d, input int b);
        chk({nm, ".count"}, int'(bus.count), c);
        chk({nm, ".tc"}, int'(bus.tc), t);
        chk({nm, ".done"}, int'(bus.done), d);
        chk({nm, ".busy"}, int'(bus.busy), b);
    endtask

    task automatic idle_in();
        bus.clear = 0; bus.en = 0; bus.up = 1; bus.mode = 2'b00;
        bus.load = 0; bus.load_val = 0; bus.cfg_we = 0;
        bus.cfg_max = 0; bus.start = 0;
    endtask

    task automatic add(input logic clr, input logic en, input logic up,
                       input logic [1:0] m, input logic ld,
                       input logic [7:0] ldv, input logic we,
                       input logic [7:0] cmax, input logic st,
                       input logic [7:0] ec, input logic etc,
                       input logic ed, input logic eb);
        vec_t v;
        v.clr = clr; v.en = en; v.up = up; v.mode = m; v.ld = ld;
        v.ldv = ldv; v.we = we; v.cmax = cmax; v.st = st;
        v.ec = ec; v.etc = etc; v.ed = ed; v.eb = eb;
        tbl.push_back(v);
    endtask

    task automatic step(input logic en, input logic up,
                        input logic [1:0] m, input logic st);
        @(negedge clk);
        idle_in();
        bus.en = en; bus.up = up; bus.mode = m; bus.start = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        idle_in();
        reset = 1'b1;
        #12;
        chk_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // WRAP up, default limit 9
        for (int k = 1; k <= 25; k++) begin
            step(1, 1, 2'b00, 0);
            chk($sformatf("wrap_up%0d.count", k), int'(bus.count), k % 10);
            chk($sformatf("wrap_up%0d.tc", k), int'(bus.tc),
                (k % 10 == 0) ? 1 : 0);
        end

        //   clr en up mode ld ldv we cmax st | cnt tc d b
        add(1, 0, 1, 2'b00, 0, 0, 1, 3, 0,   0, 0, 0, 0);
        add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0,   3, 1, 0, 0);
        add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0,   2, 0, 0, 0);
        add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0,   3, 1, 0, 0);
        add(0, 0, 1, 2'b01, 1, 2, 1, 5, 0,   2, 0, 0, 0);
        add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0,   3, 0, 0, 0);
        add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0,   4, 0, 0, 0);
        add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0,   5, 1, 0, 0);
        add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0,   5, 0, 0, 0);
        add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0,   5, 0, 0, 0);
        add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0,   5, 0, 0, 0);
        add(0, 0, 1, 2'b01, 1, 1, 0, 0, 0,   1, 0, 0, 0);
        add(0, 1, 0, 2'b01, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        add(0, 1, 0, 2'b01, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 0, 1, 2'b10, 0, 0, 1, 4, 0,   0, 0, 0, 0);
        add(0, 0, 1, 2'b10, 0, 0, 0, 0, 1,   0, 0, 0, 1);
        add(0, 1, 1, 2'b10, 0, 0, 0, 0, 0,   1, 0, 0, 1);
        add(0, 0, 1, 2'b10, 0, 0, 0, 0, 0,   1, 0, 0, 1);
        add(0, 1, 1, 2'b10, 0, 0, 0, 0, 0,   2, 0, 0, 1);
        add(0, 1, 1, 2'b10, 0, 0, 0, 0, 0,   3, 0, 0, 1);
        add(0, 1, 1, 2'b10, 0, 0, 0, 0, 0,   4, 1, 1, 0);
        add(0, 1, 1, 2'b10, 0, 0, 0, 0, 0,   4, 0, 1, 0);
        add(0, 0, 1, 2'b10, 0, 0, 0, 0, 1,   0, 0, 0, 1);
        add(0, 1, 1, 2'b10, 0, 0, 0, 0, 0,   1, 0, 0, 1);
        add(0, 1, 1, 2'b10, 0, 0, 0, 0, 1,   0, 0, 0, 1);
        add(0, 0, 0, 2'b10, 0, 0, 0, 0, 1,   4, 0, 0, 1);
        add(0, 1, 0, 2'b10, 0, 0, 0, 0, 0,   3, 0, 0, 1);
        add(0, 1, 0, 2'b10, 0, 0, 0, 0, 0,   2, 0, 0, 1);
        add(0, 1, 0, 2'b10, 0, 0, 0, 0, 0,   1, 0, 0, 1);
        add(0, 1, 0, 2'b10, 0, 0, 0, 0, 0,   0, 1, 1, 0);
        add(0, 0, 0, 2'b00, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        add(1, 1, 1, 2'b00, 1, 7, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 1, 2'b00, 1, 7, 0, 0, 0,   7, 0, 0, 0);
        add(0, 1, 1, 2'b00, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        add(0, 0, 1, 2'b00, 0, 0, 1, 0, 0,   0, 0, 0, 0);
        add(0, 1, 1, 2'b00, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 0, 2'b01, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 0, 1, 2'b11, 0, 0, 1, 9, 0,   0, 0, 0, 0);
        add(0, 1, 1, 2'b11, 0, 0, 0, 0, 0,   1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            bus.clear = tbl[i].clr; bus.en = tbl[i].en;
            bus.up = tbl[i].up; bus.mode = tbl[i].mode;
            bus.load = tbl[i].ld; bus.load_val = tbl[i].ldv;
            bus.cfg_we = tbl[i].we; bus.cfg_max = tbl[i].cmax;
            bus.start = tbl[i].st;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), int'(tbl[i].ec),
                    int'(tbl[i].etc), int'(tbl[i].ed), int'(tbl[i].eb));
        end

        // Async reset in the middle of a one-shot run
        step(0, 1, 2'b10, 1);
        step(1, 1, 2'b10, 0);
        step(1, 1, 2'b10, 0);
        chk_all("pre_rst", 2, 0, 0, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        // Limit must be back to 9: tc on the 10th wrap step
        for (int k = 1; k <= 10; k++) begin
            step(1, 1, 2'b00, 0);
            chk($sformatf("post_rst%0d.count", k), int'(bus.count), k % 10);
            chk($sformatf("post_rst%0d.tc", k), int'(bus.tc),
                (k == 10) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
